audio_io_unit: RTL
==================

Name: audio_io_unit

Overview:
Parametrised, buffered audio sample interface for the CPU top level; it replaces the direct adcdata input and the outputbool-gated DAC outport.
- Ingress: NCH ADC channels, each buffered in a FIFO and read by the CPU through a first-word-fall-through port.
- Egress: the CPU writes DAC samples into per-channel FIFOs; a sample-rate tick drains all channels together as one frame.
- Sticky overflow/underrun status per channel for software polling.

Parameters:
- DWIDTH, 32, CPU data width.
- SWIDTH, 20, audio sample width, signed two's complement; SWIDTH <= DWIDTH.
- NCH, 2, channel count, >= 2.
- DEPTH, 8, entries per FIFO, power of 2, >= 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- adc_valid  in  1  ADC sample present.
- adc_ch  in  CHW  ADC channel index; CHW = $clog2(NCH).
- adc_data  in  SWIDTH  ADC sample.
- adc_ready  out  1  ingress FIFO[adc_ch] not full.
- rd_en  in  1  CPU pops ingress FIFO[rd_ch].
- rd_ch  in  CHW  CPU read channel.
- rd_data  out  DWIDTH  head of ingress FIFO[rd_ch], sign-extended; 0 if empty.
- rd_avail  out  NCH  per-channel ingress not empty.
- wr_en  in  1  CPU pushes to egress FIFO[wr_ch].
- wr_ch  in  CHW  CPU write channel.
- wr_data  in  DWIDTH  CPU sample, signed.
- wr_full  out  NCH  per-channel egress full.
- dac_tick  in  1  sample-rate strobe, one cycle wide.
- dac_data  out  NCH*SWIDTH  current DAC frame; channel k in bits [k*SWIDTH +: SWIDTH].
- dac_valid  out  1  one-cycle pulse when a new frame loads.
- flags_clr  in  1  clears all sticky flags.
- adc_ovf  out  NCH  sticky: ADC sample dropped.
- cpu_unf  out  NCH  sticky: CPU read of an empty ingress FIFO.
- dac_ovf  out  NCH  sticky: CPU write to a full egress FIFO.
- dac_unf  out  1  sticky: tick arrived while any egress FIFO was empty.

Behaviour:
- Reset (synchronous, active-high):
  - All FIFOs empty; all flags 0; dac_data 0; dac_valid 0.
  - adc_ready 1; rd_avail 0; wr_full 0; rd_data 0.
- FIFO: 2·NCH instances, DEPTH entries each, with read pointer, write pointer and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
  - Push succeeds only when not full. Pop succeeds only when not empty.
  - Simultaneous push and pop when neither full nor empty: both succeed and count is unchanged.
  - Full with pop: pop only.
  - Empty with push: push only; the pop is an underrun.
- ADC ingress:
  - Transfer occurs on adc_valid && adc_ready at the clock edge.
  - adc_valid && !adc_ready: sample dropped and adc_ovf[adc_ch] set.
  - adc_ch >= NCH: no operation and no flag.
- CPU read:
  - rd_data is combinational from the FIFO head, with {DWIDTH-SWIDTH} copies of bit SWIDTH-1 prepended.
  - A sample accepted at edge N is visible on rd_data after edge N.
  - rd_en on a non-empty FIFO advances the head at the edge.
  - rd_en on an empty FIFO: no pop and cpu_unf[rd_ch] set.
- CPU write:
  - Stored sample is wr_data[SWIDTH-1:0] (truncation; see Optional Feature).
  - wr_en on a full FIFO: dropped and dac_ovf[wr_ch] set.
- DAC egress:
  - dac_tick with all egress FIFOs non-empty: pop one entry from each, register the frame into dac_data at that edge, dac_valid = 1 for the next cycle.
  - dac_tick with any egress FIFO empty: nothing popped, dac_data held, dac_valid 0, dac_unf set.
  - A CPU write and a tick pop on the same FIFO in the same cycle follow the FIFO simultaneity rules above.
- Flags:
  - Set has priority over flags_clr in the same cycle.
  - reset dominates everything.
  - Reset mid-stream discards all buffered samples.

Optional Feature:
AUDIO_IO_SATURATE_EN
- Defined: CPU write clamps the signed wr_data to the range [-2^(SWIDTH-1), 2^(SWIDTH-1)-1] before storing.
- Undefined: plain truncation to the low SWIDTH bits.

Decomposition:
- Package audio_io_pkg:
  - Default constants for SWIDTH, NCH and DEPTH.
  - A sample typedef, logic signed [SWIDTH-1:0].
  - Function sext_sample(sample) -> DWIDTH.
  - Function sat_sample(word) -> sample.
- Sub-module sample_fifo:
  - Parameters: width, depth.
  - Ports: push, pop, din, dout, full, empty.
  - Instantiated per channel in a generate loop for ingress and for egress.

Test Plan:
(All scenarios use NCH=2, SWIDTH=20, DEPTH=4.)
- Reset held 2 cycles, then released -> all flags 0, dac_data 0, dac_valid 0, adc_ready 1, rd_avail 2'b00.
- ADC ch0 sample 20'hFFFFF, then 20'h7FFFF -> rd_ch=0 gives rd_data 32'hFFFFFFFF. After rd_en it gives 32'h0007FFFF. After a second rd_en, rd_avail[0]=0.
- ADC ch1 receives 4 samples -> adc_ready=0 when adc_ch=1 and still 1 when adc_ch=0. A 5th valid on ch1 -> adc_ovf=2'b10, ch1 count stays 4.
- rd_en on empty ch0 -> rd_data 0, cpu_unf=2'b01. Then pulse flags_clr -> cpu_unf=2'b00.
- Write ch0=32'd5 and ch1=32'hFFFFFFFD, then dac_tick -> dac_data = {20'hFFFFD, 20'h00005}, dac_valid high for exactly one cycle. A second dac_tick -> dac_valid 0, dac_data unchanged, dac_unf=1.
- Write ch0 = 32'h00100000 then dac_tick (ch1 pre-loaded) -> ch0 frame is 20'h7FFFF with AUDIO_IO_SATURATE_EN defined, 20'h00000 without it.

Source files
------------

// File: rtl/audio_io_pkg.sv
//------------------------------------------------------------------------------
// Module   : audio_io_pkg
// Purpose  : Shared constants, sample type and conversion helpers for the
//            buffered audio I/O unit.
// Contents : DEF_* default widths/depths, sample_t, sext_sample, sat_sample.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package audio_io_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_SWIDTH = 20;
  localparam int DEF_NCH    = 2;
  localparam int DEF_DEPTH  = 8;

  typedef logic signed [DEF_SWIDTH-1:0] sample_t;

  // Sign-extend a default-width sample to the default CPU word width.
  function automatic logic [DEF_DWIDTH-1:0] sext_sample(input sample_t sample);
    return DEF_DWIDTH'(sample);
  endfunction

  // Clamp a signed CPU word into the representable sample range.
  function automatic sample_t sat_sample(input logic signed [DEF_DWIDTH-1:0] word);
    logic [DEF_DWIDTH-DEF_SWIDTH:0] hi;
    hi = word[DEF_DWIDTH-1:DEF_SWIDTH-1];
    if ((&hi) || (~|hi)) return word[DEF_SWIDTH-1:0];
    else if (word[DEF_DWIDTH-1]) return {1'b1, {(DEF_SWIDTH-1){1'b0}}};
    else return {1'b0, {(DEF_SWIDTH-1){1'b1}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
//------------------------------------------------------------------------------
// Module   : sample_fifo
// Purpose  : Single-clock FIFO with first-word-fall-through output.
//            Push is ignored when full, pop is ignored when empty; a push
//            and a pop together on a partially filled FIFO both succeed.
// Ports    : clock, reset (sync, active-high), push, pop, din, dout (head),
//            full, empty.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign dout      = mem_q[rd_ptr_q];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;  // wraps naturally, DEPTH is a power of 2
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/audio_io_unit.sv
//------------------------------------------------------------------------------
// Module   : audio_io_unit
// Purpose  : Buffered audio sample interface between ADC/DAC and the CPU.
//            Ingress: per-channel ADC FIFOs read through a FWFT port.
//            Egress : per-channel CPU-written FIFOs drained together as one
//                     frame on each dac_tick.
//            Sticky overflow/underrun flags for software polling.
// Ports    : clock, reset (sync, active-high)
//            adc_valid/adc_ch/adc_data/adc_ready     - ADC ingress
//            rd_en/rd_ch/rd_data/rd_avail            - CPU read side
//            wr_en/wr_ch/wr_data/wr_full             - CPU write side
//            dac_tick/dac_data/dac_valid             - DAC frame output
//            flags_clr, adc_ovf, cpu_unf, dac_ovf, dac_unf - status
// Config   : AUDIO_IO_SATURATE_EN - when defined, CPU writes are clamped to
//            the signed sample range instead of truncated.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module audio_io_unit
  import audio_io_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int SWIDTH = DEF_SWIDTH,
  parameter int NCH    = DEF_NCH,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int CHW   = $clog2(NCH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  adc_valid,
  input  logic [CHW-1:0]        adc_ch,
  input  logic [SWIDTH-1:0]     adc_data,
  output logic                  adc_ready,
  input  logic                  rd_en,
  input  logic [CHW-1:0]        rd_ch,
  output logic [DWIDTH-1:0]     rd_data,
  output logic [NCH-1:0]        rd_avail,
  input  logic                  wr_en,
  input  logic [CHW-1:0]        wr_ch,
  input  logic [DWIDTH-1:0]     wr_data,
  output logic [NCH-1:0]        wr_full,
  input  logic                  dac_tick,
  output logic [NCH*SWIDTH-1:0] dac_data,
  output logic                  dac_valid,
  input  logic                  flags_clr,
  output logic [NCH-1:0]        adc_ovf,
  output logic [NCH-1:0]        cpu_unf,
  output logic [NCH-1:0]        dac_ovf,
  output logic                  dac_unf
);

  logic [NCH-1:0]    w_adc_sel, w_rd_sel, w_wr_sel;
  logic [NCH-1:0]    w_ig_push, w_ig_pop, w_ig_full, w_ig_empty;
  logic [NCH-1:0]    w_eg_push, w_eg_pop, w_eg_full, w_eg_empty;
  logic [SWIDTH-1:0] w_ig_dout [NCH];
  logic [SWIDTH-1:0] w_eg_dout [NCH];
  logic [SWIDTH-1:0] w_wr_sample;
  logic              w_frame_ok;
  logic              w_unused_wr;

  logic [NCH*SWIDTH-1:0] dac_data_q, dac_data_d;
  logic                  dac_valid_q, dac_valid_d;
  logic [NCH-1:0]        adc_ovf_q, adc_ovf_d;
  logic [NCH-1:0]        cpu_unf_q, cpu_unf_d;
  logic [NCH-1:0]        dac_ovf_q, dac_ovf_d;
  logic                  dac_unf_q, dac_unf_d;

  // One-hot channel decodes; an out-of-range index selects nothing.
  always_comb begin
    w_adc_sel = '0;
    w_rd_sel  = '0;
    w_wr_sel  = '0;
    for (int k = 0; k < NCH; k++) begin
      w_adc_sel[k] = (adc_ch == CHW'(k));
      w_rd_sel[k]  = (rd_ch  == CHW'(k));
      w_wr_sel[k]  = (wr_ch  == CHW'(k));
    end
  end

  // FWFT read mux, sign-extended; reads 0 when the selected FIFO is empty.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_rd_sel[k] && !w_ig_empty[k]) rd_data = DWIDTH'($signed(w_ig_dout[k]));
    end
  end

`ifdef AUDIO_IO_SATURATE_EN
  logic [DWIDTH-SWIDTH:0] w_wr_hi;
  assign w_wr_hi = wr_data[DWIDTH-1:SWIDTH-1];
  always_comb begin
    if ((&w_wr_hi) || (~|w_wr_hi)) w_wr_sample = wr_data[SWIDTH-1:0];
    else if (wr_data[DWIDTH-1])    w_wr_sample = {1'b1, {(SWIDTH-1){1'b0}}};
    else                           w_wr_sample = {1'b0, {(SWIDTH-1){1'b1}}};
  end
`else
  assign w_wr_sample = wr_data[SWIDTH-1:0];
`endif
  // Upper word bits are intentionally discarded in truncation mode.
  assign w_unused_wr = ^wr_data;

  assign w_ig_push  = {NCH{adc_valid}} & w_adc_sel;
  assign w_ig_pop   = {NCH{rd_en}} & w_rd_sel;
  assign w_eg_push  = {NCH{wr_en}} & w_wr_sel;
  assign w_frame_ok = dac_tick && !(|w_eg_empty);
  assign w_eg_pop   = {NCH{w_frame_ok}};

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      sample_fifo #(.WIDTH(SWIDTH), .DEPTH(DEPTH)) u_ig_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_ig_push[g]),
        .pop   (w_ig_pop[g]),
        .din   (adc_data),
        .dout  (w_ig_dout[g]),
        .full  (w_ig_full[g]),
        .empty (w_ig_empty[g])
      );
      sample_fifo #(.WIDTH(SWIDTH), .DEPTH(DEPTH)) u_eg_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_eg_push[g]),
        .pop   (w_eg_pop[g]),
        .din   (w_wr_sample),
        .dout  (w_eg_dout[g]),
        .full  (w_eg_full[g]),
        .empty (w_eg_empty[g])
      );
    end
  endgenerate

  always_comb begin
    dac_data_d  = dac_data_q;
    dac_valid_d = w_frame_ok;
    if (w_frame_ok) begin
      for (int k = 0; k < NCH; k++) dac_data_d[k*SWIDTH +: SWIDTH] = w_eg_dout[k];
    end
    // Sticky flags: a new event in the same cycle as flags_clr survives.
    adc_ovf_d = (adc_ovf_q & ~{NCH{flags_clr}}) | (w_ig_push & w_ig_full);
    cpu_unf_d = (cpu_unf_q & ~{NCH{flags_clr}}) | (w_ig_pop & w_ig_empty);
    dac_ovf_d = (dac_ovf_q & ~{NCH{flags_clr}}) | (w_eg_push & w_eg_full);
    dac_unf_d = (dac_unf_q & !flags_clr) | (dac_tick && (|w_eg_empty));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      adc_ovf_q   <= '0;
      cpu_unf_q   <= '0;
      dac_ovf_q   <= '0;
      dac_unf_q   <= 1'b0;
    end else begin
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      adc_ovf_q   <= adc_ovf_d;
      cpu_unf_q   <= cpu_unf_d;
      dac_ovf_q   <= dac_ovf_d;
      dac_unf_q   <= dac_unf_d;
    end
  end

  assign adc_ready = |(w_adc_sel & ~w_ig_full);
  assign rd_avail  = ~w_ig_empty;
  assign wr_full   = w_eg_full;
  assign dac_data  = dac_data_q;
  assign dac_valid = dac_valid_q;
  assign adc_ovf   = adc_ovf_q;
  assign cpu_unf   = cpu_unf_q;
  assign dac_ovf   = dac_ovf_q;
  assign dac_unf   = dac_unf_q;

endmodule

`default_nettype wire
